// File: rtl/counter_cdc_pkg.sv
// ============================================================================
// Module   : counter_cdc_pkg
// Purpose  : Gray/binary conversion helpers shared by the gray-count CDC slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package counter_cdc_pkg;

  localparam int SYNC_MIN = 2;
  localparam int MAX_W    = 32;

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    width_mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin, input int width);
    logic [MAX_W-1:0] b;
    b        = bin & width_mask(width);
    bin2gray = b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of every gray bit at or above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray, input int width);
    logic [MAX_W-1:0] g;
    g        = gray & width_mask(width);
    gray2bin = '0;
    for (int i = 0; i < MAX_W; i++) begin
      gray2bin[i] = ^(g >> i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_sync_chan.sv
// ============================================================================
// Module   : gray_sync_chan
// Purpose  : One counter channel: domain-A gray counter, domain-B sync chain,
//            decode register and update strobe (delta with COUNTER_ASYNC_DELTA_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray_sync_chan
  import counter_cdc_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk_a,
  input  logic              i_rst_a_n,
  input  logic              i_clk_b,
  input  logic              i_rst_b_n,
  input  logic              i_inc,
  output logic [DWIDTH-1:0] o_cnt_a,
  output logic [DWIDTH-1:0] o_cnt_b,
`ifdef COUNTER_ASYNC_DELTA_EN
  output logic [DWIDTH-1:0] o_delta,
`endif
  output logic              o_upd
);

  localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

  logic [DWIDTH-1:0] r_bin;
  logic [DWIDTH-1:0] r_gray;
  logic [DWIDTH-1:0] w_bin_nxt;
  logic [DWIDTH-1:0] w_dec;
  logic [DWIDTH-1:0] r_cnt_b;
  logic              r_upd;
  (* ASYNC_REG = "TRUE" *) logic [DWIDTH-1:0] r_sync [SYNC_N];

  assign w_bin_nxt = r_bin + DWIDTH'(1);

  always_ff @(posedge i_clk_a or negedge i_rst_a_n) begin
    if (!i_rst_a_n) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else if (i_inc) begin
      r_bin  <= w_bin_nxt;
      r_gray <= DWIDTH'(bin2gray(MAX_W'(w_bin_nxt), DWIDTH));
    end
  end

  always_ff @(posedge i_clk_b or negedge i_rst_b_n) begin
    if (!i_rst_b_n) begin
      for (int s = 0; s < SYNC_N; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= r_gray;
      for (int s = 1; s < SYNC_N; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_dec = DWIDTH'(gray2bin(MAX_W'(r_sync[SYNC_N-1]), DWIDTH));

  always_ff @(posedge i_clk_b or negedge i_rst_b_n) begin
    if (!i_rst_b_n) begin
      r_cnt_b <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_cnt_b <= w_dec;
      r_upd   <= (w_dec != r_cnt_b);
    end
  end

`ifdef COUNTER_ASYNC_DELTA_EN
  logic [DWIDTH-1:0] r_delta;

  // Modular difference, so a wrap through zero still reports the true step.
  always_ff @(posedge i_clk_b or negedge i_rst_b_n) begin
    if (!i_rst_b_n) begin
      r_delta <= '0;
    end else if (w_dec != r_cnt_b) begin
      r_delta <= w_dec - r_cnt_b;
    end
  end

  assign o_delta = r_delta;
`endif

  assign o_cnt_a = r_bin;
  assign o_cnt_b = r_cnt_b;
  assign o_upd   = r_upd;

endmodule

`default_nettype wire

// File: rtl/counter_async_gray_multi.sv
// ============================================================================
// Module   : counter_async_gray_multi
// Purpose  : CH_NUM gray-coded counters crossing from i_clk_a to i_clk_b.
//            Optional o_delta port with macro COUNTER_ASYNC_DELTA_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module counter_async_gray_multi #(
  parameter int CH_NUM      = 4,
  parameter int DWIDTH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int U_DLY       = 1
) (
  input  logic                     i_clk_a,
  input  logic                     i_rst_a_n,
  input  logic                     i_clk_b,
  input  logic                     i_rst_b_n,
  input  logic [CH_NUM-1:0]        i_inc,
  output logic [CH_NUM*DWIDTH-1:0] o_cnt_a,
  output logic [CH_NUM*DWIDTH-1:0] o_cnt_b,
`ifdef COUNTER_ASYNC_DELTA_EN
  output logic [CH_NUM*DWIDTH-1:0] o_delta,
`endif
  output logic [CH_NUM-1:0]        o_upd
);

  // Registers are zero-delay in this view; U_DLY only keeps the interface stable.
  if (U_DLY < 0) begin : g_udly_unused
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
    gray_sync_chan #(
      .DWIDTH      (DWIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .i_clk_a   (i_clk_a),
      .i_rst_a_n (i_rst_a_n),
      .i_clk_b   (i_clk_b),
      .i_rst_b_n (i_rst_b_n),
      .i_inc     (i_inc[c]),
      .o_cnt_a   (o_cnt_a[c*DWIDTH +: DWIDTH]),
      .o_cnt_b   (o_cnt_b[c*DWIDTH +: DWIDTH]),
`ifdef COUNTER_ASYNC_DELTA_EN
      .o_delta   (o_delta[c*DWIDTH +: DWIDTH]),
`endif
      .o_upd     (o_upd[c])
    );
  end

endmodule

`default_nettype wire
